// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, constants and helpers for the parametrised Moore sequence detector
package seq_det_pkg;

    localparam int MAX_W = 16;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_STEP,
        ACT_LOAD
    } seq_act_e;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // True when the newest j bits of hist equal the first j pattern bits (MSB received first).
    function automatic logic prefix_match(
        input logic [MAX_W-1:0] hist,
        input logic [MAX_W-1:0] pat,
        input int               pat_w,
        input int               j
    );
        logic       ok;
        logic [3:0] idx;
        ok = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            idx = 4'(pat_w - j + i);
            if (i < j && hist[4'(i)] != pat[idx]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// rtl/seq_det_next_state.sv - combinational next-state logic: longest suffix of history that is a pattern prefix
module seq_det_next_state
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int SW    = state_w(PAT_W)
) (
    input  logic [SW-1:0]    state,
    input  logic [PAT_W-1:0] history,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic [SW-1:0]    next_state
);

    logic             restart;
    logic [PAT_W-1:0] h;
    int               lim;

    always_comb begin
        restart    = !overlap && (state == SW'(PAT_W));
        h          = {history[PAT_W-2:0], x};
        lim        = int'(state) + 1;
        next_state = '0;
        if (restart) begin
            h   = {{(PAT_W-1){1'b0}}, x};
            lim = 1;
        end
        if (lim > PAT_W) begin
            lim = PAT_W;
        end
        // The suffix can grow by at most one bit per step, so j is bounded by state+1.
        for (int j = 1; j <= PAT_W; j++) begin
            if (j <= lim && prefix_match(MAX_W'(h), MAX_W'(pattern), PAT_W, j)) begin
                next_state = SW'(j);
            end
        end
    end

endmodule

// File: rtl/seq_detector_moore_param.sv
// rtl/seq_detector_moore_param.sv - parametrised Moore pattern detector with saturating count; SEQ_DET_PAT_LOAD_EN adds runtime pattern load
module seq_detector_moore_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x,
    input  logic                         x_valid,
`ifdef SEQ_DET_PAT_LOAD_EN
    input  logic                         pat_ld,
    input  logic [PAT_W-1:0]             pat_in,
`endif
    output logic                         z,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_W+1)-1:0]   state
);

    localparam int SW = state_w(PAT_W);

    logic [PAT_W-1:0] history;
    logic [PAT_W-1:0] history_d;
    logic [PAT_W-1:0] pattern;
    logic [SW-1:0]    state_d;
    logic [SW-1:0]    step_state;
    logic [CNT_W-1:0] match_cnt_d;
    logic             load;
    seq_act_e         act;

`ifdef SEQ_DET_PAT_LOAD_EN
    assign load = pat_ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= PATTERN;
        end else if (pat_ld) begin
            pattern <= pat_in;
        end
    end
`else
    assign load    = 1'b0;
    assign pattern = PATTERN;
`endif

    seq_det_next_state #(
        .PAT_W (PAT_W),
        .SW    (SW)
    ) u_next_state (
        .state      (state),
        .history    (history),
        .x          (x),
        .pattern    (pattern),
        .overlap    (OVERLAP != 0),
        .next_state (step_state)
    );

    always_comb begin
        act         = ACT_HOLD;
        state_d     = state;
        history_d   = history;
        match_cnt_d = match_cnt;
        if (load) begin
            act = ACT_LOAD;
        end else if (x_valid) begin
            act = ACT_STEP;
        end
        case (act)
            ACT_LOAD: begin
                state_d   = '0;
                history_d = '0;
            end
            ACT_STEP: begin
                state_d   = step_state;
                history_d = {history[PAT_W-2:0], x};
                // Any entry into accept counts, including an accept self-loop.
                if (step_state == SW'(PAT_W) && match_cnt != '1) begin
                    match_cnt_d = match_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= '0;
            history   <= '0;
            match_cnt <= '0;
        end else begin
            state     <= state_d;
            history   <= history_d;
            match_cnt <= match_cnt_d;
        end
    end

    assign z = (state == SW'(PAT_W));

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// tb/tb_seq_detector_moore_param.sv - self-checking bench: vector table, corner sequences, random stream vs reference model
module tb_seq_detector_moore_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
`ifdef SEQ_DET_PAT_LOAD_EN
    logic       pat_ld = 1'b0;
    logic [3:0] pat_in4 = 4'b0;
    logic [1:0] pat_in2 = 2'b0;
`endif

    logic       z_ov, z_nov, z_11;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_11;
    logic [2:0] st_ov, st_nov;
    logic [1:0] st_11;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seq_detector_moore_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
`ifdef SEQ_DET_PAT_LOAD_EN
        .pat_ld(pat_ld), .pat_in(pat_in4),
`endif
        .z(z_ov), .match_cnt(cnt_ov), .state(st_ov));

    seq_detector_moore_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
`ifdef SEQ_DET_PAT_LOAD_EN
        .pat_ld(pat_ld), .pat_in(pat_in4),
`endif
        .z(z_nov), .match_cnt(cnt_nov), .state(st_nov));

    seq_detector_moore_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_11 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
`ifdef SEQ_DET_PAT_LOAD_EN
        .pat_ld(pat_ld), .pat_in(pat_in2),
`endif
        .z(z_11), .match_cnt(cnt_11), .state(st_11));

    // Reference model: full bit history since the last clear, state found by brute-force search.
    typedef struct {
        int          pw;
        logic [15:0] dpat;
        logic [15:0] pat;
        bit          ov;
        int          cmax;
        logic [31:0] hist;
        int          len;
        int          st;
        int          cnt;
    } mdl_t;

    mdl_t m_ov, m_nov, m_11;

    typedef struct {
        bit x;
        int st_ov;
        int cnt_ov;
        int st_nov;
        int cnt_nov;
    } vec_t;

    vec_t tbl[16];

    function automatic int longest(mdl_t m);
        logic [31:0] mask;
        for (int j = m.pw; j >= 1; j--) begin
            mask = (32'd1 << j) - 32'd1;
            if (j <= m.len && (m.hist & mask) == ((32'(m.pat) >> (m.pw - j)) & mask))
                return j;
        end
        return 0;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit r, bit ld, logic [15:0] pin, bit v, bit b);
        if (r) begin
            m.pat = m.dpat; m.hist = 0; m.len = 0; m.st = 0; m.cnt = 0;
        end else if (ld) begin
            m.pat = pin; m.hist = 0; m.len = 0; m.st = 0;
        end else if (v) begin
            if (!m.ov && m.st == m.pw) begin
                m.hist = 0; m.len = 0;
            end
            m.hist = {m.hist[30:0], b};
            if (m.len < 32) m.len++;
            m.st = longest(m);
            if (m.st == m.pw && m.cnt < m.cmax) m.cnt++;
        end
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit b, input bit ld,
                        input logic [3:0] p4, input logic [1:0] p2);
        rst = r; x_valid = v; x = b;
`ifdef SEQ_DET_PAT_LOAD_EN
        pat_ld = ld; pat_in4 = p4; pat_in2 = p2;
`endif
        m_ov  = mstep(m_ov,  r, ld, 16'(p4), v, b);
        m_nov = mstep(m_nov, r, ld, 16'(p4), v, b);
        m_11  = mstep(m_11,  r, ld, 16'(p2), v, b);
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input bit b);
        step(1'b0, 1'b1, b, 1'b0, 4'b0, 2'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 2'b0);
    endtask

    task automatic check_models();
        chk("rand.ov.state",  int'(st_ov),   m_ov.st);
        chk("rand.ov.z",      int'(z_ov),    int'(m_ov.st == 4));
        chk("rand.ov.cnt",    int'(cnt_ov),  m_ov.cnt);
        chk("rand.nov.state", int'(st_nov),  m_nov.st);
        chk("rand.nov.z",     int'(z_nov),   int'(m_nov.st == 4));
        chk("rand.nov.cnt",   int'(cnt_nov), m_nov.cnt);
        chk("rand.11.state",  int'(st_11),   m_11.st);
        chk("rand.11.z",      int'(z_11),    int'(m_11.st == 2));
        chk("rand.11.cnt",    int'(cnt_11),  m_11.cnt);
    endtask

    initial begin
        logic [15:0] stream;
        int e_st_ov[16]   = '{0,0,0,1,2,3,4,2,3,4,1,2,0,0,0,0};
        int e_cnt_ov[16]  = '{0,0,0,0,0,0,1,1,1,2,2,2,2,2,2,2};
        int e_st_nov[16]  = '{0,0,0,1,2,3,4,0,1,1,1,2,0,0,0,0};
        int e_cnt_nov[16] = '{0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,1};
        int e_cnt_11[6]   = '{0,1,2,3,3,3};
        logic [3:0] p1011;

        m_ov  = '{pw:4, dpat:16'hB, pat:16'hB, ov:1'b1, cmax:255, hist:0, len:0, st:0, cnt:0};
        m_nov = '{pw:4, dpat:16'hB, pat:16'hB, ov:1'b0, cmax:255, hist:0, len:0, st:0, cnt:0};
        m_11  = '{pw:2, dpat:16'h3, pat:16'h3, ov:1'b1, cmax:3,   hist:0, len:0, st:0, cnt:0};

        stream = 16'b0001011011100000;
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{x:stream[15-i], st_ov:e_st_ov[i], cnt_ov:e_cnt_ov[i],
                       st_nov:e_st_nov[i], cnt_nov:e_cnt_nov[i]};
        end

        // Reset state.
        do_reset();
        chk("reset.ov.state", int'(st_ov), 0);
        chk("reset.ov.z",     int'(z_ov), 0);
        chk("reset.ov.cnt",   int'(cnt_ov), 0);
        chk("reset.11.state", int'(st_11), 0);

        // Overlapping vs non-overlapping on the same stream.
        for (int i = 0; i < 16; i++) begin
            bit_in(tbl[i].x);
            chk($sformatf("tbl[%0d].ov.state", i),  int'(st_ov),   tbl[i].st_ov);
            chk($sformatf("tbl[%0d].ov.z", i),      int'(z_ov),    int'(tbl[i].st_ov == 4));
            chk($sformatf("tbl[%0d].ov.cnt", i),    int'(cnt_ov),  tbl[i].cnt_ov);
            chk($sformatf("tbl[%0d].nov.state", i), int'(st_nov),  tbl[i].st_nov);
            chk($sformatf("tbl[%0d].nov.z", i),     int'(z_nov),   int'(tbl[i].st_nov == 4));
            chk($sformatf("tbl[%0d].nov.cnt", i),   int'(cnt_nov), tbl[i].cnt_nov);
        end

        // Idle gaps between valid bits must not move anything.
        do_reset();
        p1011 = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            bit_in(p1011[3-k]);
            chk("gap.state.valid", int'(st_ov), k + 1);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 4'b0, 2'b0);
                chk("gap.state.hold", int'(st_ov), k + 1);
                chk("gap.z.hold", int'(z_ov), int'(k == 3));
            end
        end
        chk("gap.cnt", int'(cnt_ov), 1);

        // Reset mid-pattern wins over a valid bit and clears the count.
        do_reset();
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        bit_in(0); bit_in(1);
        chk("midrst.pre.state", int'(st_ov), 3);
        chk("midrst.pre.cnt", int'(cnt_ov), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 2'b0);
        chk("midrst.rst.state", int'(st_ov), 0);
        chk("midrst.rst.cnt", int'(cnt_ov), 0);
        bit_in(1);
        chk("midrst.after.state", int'(st_ov), 1);
        chk("midrst.after.z", int'(z_ov), 0);
        chk("midrst.after.cnt", int'(cnt_ov), 0);

        // Accept self-loop and counter saturation on the 2-bit all-ones detector.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bit_in(1);
            chk("sat.11.z", int'(z_11), int'(k >= 1));
            chk("sat.11.state", int'(st_11), (k >= 1) ? 2 : 1);
            chk("sat.11.cnt", int'(cnt_11), e_cnt_11[k]);
        end

`ifdef SEQ_DET_PAT_LOAD_EN
        // Pattern load drops the coincident bit and keeps the count.
        do_reset();
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("load.pre.cnt", int'(cnt_ov), 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 2'b11);
        chk("load.state", int'(st_ov), 0);
        chk("load.z", int'(z_ov), 0);
        chk("load.cnt", int'(cnt_ov), 1);
        bit_in(0); bit_in(1); bit_in(1); bit_in(0);
        chk("load.match.z", int'(z_ov), 1);
        chk("load.match.state", int'(st_ov), 4);
        chk("load.match.cnt", int'(cnt_ov), 2);
`endif

        // Random stream against the reference model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            bit r, v, b, ld;
            r  = ($urandom_range(63) == 0);
            v  = ($urandom_range(3) != 0);
            b  = 1'($urandom_range(1));
            ld = 1'b0;
`ifdef SEQ_DET_PAT_LOAD_EN
            ld = ($urandom_range(49) == 0);
`endif
            step(r, v, b, ld, 4'($urandom_range(15)), 2'($urandom_range(3)));
            check_models();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_moore_param.md
Name: seq_detector_moore_param

Overview:
Parametrised Moore serial-pattern detector, the successor to the fixed 1011 Moore detector. Pattern, pattern length, overlap mode and match-counter width are set at elaboration. A qualifying input strobe is added and a saturating match count is kept. The block sits on a serial bit stream and flags a completed pattern through a registered, state-decoded output.

Parameters:
PAT_W, 4, pattern length in bits (2..16).
PATTERN, 4'b1011, pattern bits; MSB is the first bit received.
OVERLAP, 1, 1 = overlapping detection; 0 = restart from empty after each match.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
x  in  1  serial data bit.
x_valid  in  1  x is sampled only on a posedge where x_valid=1.
z  out  1  Moore output; 1 while the FSM is in the accept state.
match_cnt  out  CNT_W  number of matches since reset; saturates at all-ones.
state  out  $clog2(PAT_W+1)  current FSM state (debug).

Behaviour:
- Reset: one clock, synchronous, active-high. On a posedge with rst=1: state=0, history=0, z=0, match_cnt=0. rst overrides x_valid and any load.
- States: S0..S_PAT_W. Sk means the longest suffix of accepted bits that equals a pattern prefix has length k. S_PAT_W is the accept state.
- Moore output: z = (state==PAT_W), decoded from the state register only; no combinational path from x.
- Next state on a posedge with x_valid=1:
  - Let h = the last PAT_W accepted bits, including the new x.
  - OVERLAP=1, or current state < PAT_W: next = the largest j in 0..min(state+1, PAT_W) such that the last j bits of h equal PATTERN[PAT_W-1 -: j].
  - OVERLAP=0 and current state = PAT_W: evaluate as if from S0; the history is treated as empty before x.
- x_valid=0: state, history, z and match_cnt all hold. Bits are not skipped.
- Latency: z rises on the clock edge that samples the final pattern bit. It is visible in the following cycle and holds until the next valid bit is accepted.
- match_cnt: increments by 1 on every transition into S_PAT_W. A self-loop S_PAT_W->S_PAT_W counts as a new match, which is possible only for patterns like 11..1 with OVERLAP=1. At all-ones it stays all-ones; there is no wrap.
- Back-to-back matches: with overlap, z may stay high across consecutive valid bits. match_cnt increments for each match.
- Reset mid-pattern: partial progress is discarded and the count is cleared.

Optional Feature:
SEQ_DET_PAT_LOAD_EN
- Defined: adds ports pat_ld (in, 1) and pat_in (in, PAT_W).
  - The pattern register resets to PATTERN.
  - A posedge with pat_ld=1 (and rst=0) loads pat_in and forces state=0, history=0, z=0; match_cnt holds.
  - pat_ld wins over x_valid on the same edge: that bit is dropped.
- Undefined: the pattern is the constant PATTERN and the extra ports are absent.

Decomposition:
- Package seq_det_pkg:
  - state-width function (clog2 of PAT_W+1);
  - default pattern constant;
  - prefix-match helper function (suffix of history vs. pattern prefix, length j).
- Sub-module seq_det_next_state: combinational next-state logic.
  - Inputs: state, history, x, pattern, overlap flag.
  - Output: next state.
  - Keeps the top level to registers, counter and output decode.

Test Plan:
1. Default parameters, x_valid=1, stream 0001011011100000 (MSB first), OVERLAP=1 -> z pulses for one cycle twice, after bit index 6 and bit index 9 (0-based); match_cnt=2.
2. Same stream with OVERLAP=0 -> z pulses once, after bit index 6; match_cnt=1.
3. Stream 1011 with x_valid low for 3 cycles between each bit -> state holds during gaps; z=1 only after the 4th valid bit; match_cnt=1.
4. rst asserted for one clock after 101 has been received (state=3), then 1 fed -> state=1, z=0, match_cnt=0.
5. CNT_W=2, PATTERN=2'b11, PAT_W=2, OVERLAP=1, six consecutive 1s -> z high from the 2nd bit onward; match_cnt sequence 1,2,3,3,3.
6. With SEQ_DET_PAT_LOAD_EN: load 4'b0110 mid-stream with x_valid=1 on the same edge -> that bit is ignored and state=0; subsequent stream 0110 -> z=1; match_cnt = previous value + 1.
